// File: rtl/fifo_sync_fwft.sv
// rtl/fifo_sync_fwft.sv - synchronous first-word-fall-through FIFO with flags, flush and high watermark
module fifo_sync_fwft #(
  parameter int FIFO_DEPTH    = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  localparam int CW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic [CW-1:0]         count_o,
  output logic                  afull_o,
  output logic                  aempty_o,
  input  logic                  wm_clr_i,
  output logic [CW-1:0]         max_count_o
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW-1:0] wptr_next, rptr_next;
  logic [CW-1:0] count_q, count_next;
  logic [CW-1:0] max_q, max_next;
  logic          afull_q, aempty_q;

  logic full, empty, push, pop;

  // Handshake status comes only from registered pointers, so neither ready
  // nor valid has a combinational path from the opposite side's inputs.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  assign push = in_valid_i && !full;
  assign pop  = out_ready_i && !empty;

  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign out_data_o  = mem[rptr_q[AW-1:0]];

  assign count_o     = count_q;
  assign afull_o     = afull_q;
  assign aempty_o    = aempty_q;
  assign max_count_o = max_q;

  // Next pointer and occupancy values; flush discards any same-cycle traffic.
  always_comb begin
    wptr_next  = wptr_q;
    rptr_next  = rptr_q;
    count_next = count_q;
    if (flush_i) begin
      wptr_next  = '0;
      rptr_next  = '0;
      count_next = '0;
    end else begin
      if (push) wptr_next = wptr_q + PW'(1);
      if (pop)  rptr_next = rptr_q + PW'(1);
      if (push && !pop)      count_next = count_q + CW'(1);
      else if (pop && !push) count_next = count_q - CW'(1);
    end
  end

  // Watermark follows the count being registered; a clear restarts it there.
  always_comb begin
    max_next = max_q;
    if (wm_clr_i)                 max_next = count_next;
    else if (count_next > max_q)  max_next = count_next;
  end

  // Storage array is not reset; the head is only observed while valid.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i && !rst_i) mem[wptr_q[AW-1:0]] <= in_data_i;
  end

  // Control state: pointers, count, registered flags and watermark.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      max_q    <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_next;
      rptr_q   <= rptr_next;
      count_q  <= count_next;
      max_q    <= max_next;
      afull_q  <= (count_next >= CW'(AFULL_THRESH));
      aempty_q <= (count_next <= CW'(AEMPTY_THRESH));
    end
  end

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// tb/tb_fifo_sync_fwft.sv - directed self-checking bench for fifo_sync_fwft
module tb_fifo_sync_fwft;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          afull;
  logic          aempty;
  logic          wm_clr = 1'b0;
  logic [CW-1:0] max_count;

  int checks = 0;
  int errors = 0;

  fifo_sync_fwft #(
    .FIFO_DEPTH(DEPTH),
    .DATA_WIDTH(DW),
    .AFULL_THRESH(3),
    .AEMPTY_THRESH(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .in_valid_i(in_valid),
    .in_data_i(in_data),
    .in_ready_o(in_ready),
    .out_valid_o(out_valid),
    .out_data_o(out_data),
    .out_ready_i(out_ready),
    .count_o(count),
    .afull_o(afull),
    .aempty_o(aempty),
    .wm_clr_i(wm_clr),
    .max_count_o(max_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [DW-1:0] exp);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with traffic present
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_aempty", 32'(aempty), 32'd1);
    check_eq("rst_afull", 32'(afull), 32'd0);
    check_eq("rst_max", 32'(max_count), 32'd0);

    // Fill to full, flags per count
    for (int i = 0; i < 4; i++) begin
      push_one(8'hA0 + 8'(i));
      check_eq("fill_count", 32'(count), 32'(i + 1));
      check_eq("fill_afull", 32'(afull), 32'((i + 1) >= 3));
      check_eq("fill_aempty", 32'(aempty), 32'((i + 1) <= 1));
      check_eq("fill_in_ready", 32'(in_ready), 32'((i + 1) < 4));
      check_eq("fill_head", 32'(out_data), 32'h A0);
    end
    push_one(8'hA4);
    check_eq("overrun_count", 32'(count), 32'd4);
    check_eq("fill_max", 32'(max_count), 32'd4);
    for (int i = 0; i < 4; i++) pop_check("drain", 8'hA0 + 8'(i));
    check_eq("drain_out_valid", 32'(out_valid), 32'd0);
    check_eq("drain_count", 32'(count), 32'd0);
    check_eq("drain_aempty", 32'(aempty), 32'd1);

    // Underrun: pop on empty is ignored
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check_eq("underrun_count", 32'(count), 32'd0);

    // Full with simultaneous valid and ready: only the pop happens
    for (int i = 0; i < 4; i++) push_one(8'hA0 + 8'(i));
    in_valid = 1'b1; in_data = 8'hA4; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("fullpp_count", 32'(count), 32'd3);
    check_eq("fullpp_in_ready", 32'(in_ready), 32'd1);
    for (int i = 1; i < 4; i++) pop_check("fullpp_drain", 8'hA0 + 8'(i));
    check_eq("fullpp_empty", 32'(out_valid), 32'd0);

    // Streaming across pointer wraps
    push_one(8'h10);
    push_one(8'h11);
    for (int k = 0; k < 40; k++) begin
      check_eq("stream_data", 32'(out_data), 32'(8'h10 + 8'(k)));
      in_valid = 1'b1; in_data = 8'h12 + 8'(k); out_ready = 1'b1;
      tick();
      check_eq("stream_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    pop_check("stream_tail", 8'h38);
    pop_check("stream_tail", 8'h39);
    check_eq("stream_empty", 32'(out_valid), 32'd0);

    // Clear watermark, then flush at count 3 with traffic present
    wm_clr = 1'b1; tick(); wm_clr = 1'b0;
    check_eq("wm_clr_empty", 32'(max_count), 32'd0);
    push_one(8'hC0); push_one(8'hC1); push_one(8'hC2);
    check_eq("preflush_max", 32'(max_count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_out_valid", 32'(out_valid), 32'd0);
    check_eq("flush_max", 32'(max_count), 32'd3);
    check_eq("flush_aempty", 32'(aempty), 32'd1);
    push_one(8'h55);
    check_eq("postflush_count", 32'(count), 32'd1);
    pop_check("postflush", 8'h55);

    // Watermark: reach 4, drain to 1, clear, push to 2
    for (int i = 0; i < 4; i++) push_one(8'hD0 + 8'(i));
    check_eq("wm_peak", 32'(max_count), 32'd4);
    for (int i = 0; i < 3; i++) pop_check("wm_drain", 8'hD0 + 8'(i));
    check_eq("wm_count1", 32'(count), 32'd1);
    check_eq("wm_hold", 32'(max_count), 32'd4);
    wm_clr = 1'b1; tick(); wm_clr = 1'b0;
    check_eq("wm_cleared", 32'(max_count), 32'd1);
    push_one(8'hE0);
    check_eq("wm_regrow", 32'(max_count), 32'd2);
    check_eq("wm_head", 32'(out_data), 32'h D3);

    // Reset mid-stream discards contents
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hF0;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check_eq("midrst_count", 32'(count), 32'd0);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_max", 32'(max_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
